// File: rtl/if_fetch_queue.sv
// ---------------------------------------------------------------------------
// if_fetch_queue
//
// Instruction-fetch stage with a prefetch FIFO. It generates the fetch PC,
// issues in-order requests to instruction memory and buffers the returned
// instructions together with their PCs. The FIFO head is presented to the
// decode stage in show-ahead form. A branch redirect flushes the FIFO and
// arranges for every response still in flight to be discarded.
//
// Parameters:
//   XLEN     - PC / address width
//   ILEN     - instruction width
//   DEPTH    - prefetch FIFO entries (power of two, at least 2)
//   RESET_PC - first fetch address after reset
//
// Ports:
//   clk            - clock, rising edge
//   rst            - asynchronous reset, active low
//   branch_ctrl    - 00 sequential, 01 -> pc_imm, 10 -> pc_immrs1, 11 sequential
//   pc_imm         - PC-relative redirect target
//   pc_immrs1      - register-relative redirect target
//   imem_req_valid - fetch request valid
//   imem_req_ready - memory accepts the request
//   imem_req_addr  - fetch address (word aligned)
//   imem_rsp_valid - response valid (in order, no backpressure)
//   imem_rsp_data  - fetched instruction
//   id_valid       - FIFO head valid
//   id_ready       - decode accepts the head
//   id_pc          - PC of the head instruction (0 while id_valid is 0)
//   id_instr       - head instruction (0 while id_valid is 0)
//
// Optional feature, enabled by defining IF_PERF_CNT_EN:
//   perf_fetched   - instructions handed to decode (wraps at 2^32)
//   perf_flushed   - FIFO entries flushed plus responses dropped (wraps)
// ---------------------------------------------------------------------------
module if_fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              ILEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      branch_ctrl,
  input  logic [XLEN-1:0] pc_imm,
  input  logic [XLEN-1:0] pc_immrs1,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_pc,
  output logic [ILEN-1:0] id_instr
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_flushed
`endif
);

  // Pointer width carries one extra wrap bit so full and empty differ.
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0]   CNT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0]   CNT_ONE   = CW'(32'd1);
  localparam logic [CW:0]     DEPTH_LIM = (CW + 1)'(DEPTH);
  localparam logic [XLEN-1:0] PC_STEP   = XLEN'(32'd4);
  localparam logic [XLEN-1:0] PC_ZERO   = {XLEN{1'b0}};
  localparam logic [ILEN-1:0] INSTR_ZERO = {ILEN{1'b0}};
  localparam logic [XLEN-1:0] WORD_MASK = {{(XLEN-2){1'b1}}, 2'b00};
  localparam logic [XLEN-1:0] RESET_PC_ALIGNED = RESET_PC & WORD_MASK;

  // FIFO storage and bookkeeping
  logic [XLEN-1:0] pc_mem_r    [DEPTH];
  logic [ILEN-1:0] instr_mem_r [DEPTH];
  logic [CW-1:0]   wr_ptr_r;
  logic [CW-1:0]   rd_ptr_r;
  logic [CW-1:0]   count_s;

  // Fetch-side state
  logic [XLEN-1:0] fetch_pc_r;
  logic [XLEN-1:0] rsp_pc_r;
  logic [CW-1:0]   outstanding_r;
  logic [CW-1:0]   outstanding_next_s;
  logic [CW-1:0]   drop_r;
  logic            active_r;

  // Per-cycle decisions
  logic            redirect_s;
  logic [XLEN-1:0] target_raw_s;
  logic [XLEN-1:0] target_s;
  logic [CW:0]     credit_sum_s;
  logic            req_valid_s;
  logic            req_fire_s;
  logic            head_valid_s;
  logic            pop_s;
  logic            push_s;
  logic            drop_hit_s;

  assign count_s = wr_ptr_r - rd_ptr_r;

  // Decode branch_ctrl into a redirect flag and its (unaligned) target.
  always_comb begin
    redirect_s   = 1'b0;
    target_raw_s = PC_ZERO;
    case (branch_ctrl)
      2'b01: begin
        redirect_s   = 1'b1;
        target_raw_s = pc_imm;
      end
      2'b10: begin
        redirect_s   = 1'b1;
        target_raw_s = pc_immrs1;
      end
      default: begin
        redirect_s   = 1'b0;
        target_raw_s = PC_ZERO;
      end
    endcase
  end

  assign target_s = target_raw_s & WORD_MASK;

  // Requests are limited so that every outstanding response is guaranteed
  // a FIFO slot; this is what makes a push onto a full FIFO impossible.
  assign credit_sum_s = {1'b0, count_s} + {1'b0, outstanding_r};
  assign req_valid_s  = active_r & ~redirect_s & (credit_sum_s < DEPTH_LIM);
  assign req_fire_s   = req_valid_s & imem_req_ready;

  assign head_valid_s = (count_s != CNT_ZERO) & ~redirect_s;
  assign pop_s        = head_valid_s & id_ready;

  // A response is dropped while stale responses remain, or when it lands in
  // the redirect cycle itself.
  assign drop_hit_s = imem_rsp_valid & (drop_r != CNT_ZERO);
  assign push_s     = imem_rsp_valid & ~redirect_s & (drop_r == CNT_ZERO);

  // Next outstanding-request count from accept/return events.
  always_comb begin
    outstanding_next_s = outstanding_r;
    case ({req_fire_s, imem_rsp_valid})
      2'b10:   outstanding_next_s = outstanding_r + CNT_ONE;
      2'b01:   outstanding_next_s = outstanding_r - CNT_ONE;
      default: outstanding_next_s = outstanding_r;
    endcase
  end

  assign imem_req_valid = req_valid_s;
  assign imem_req_addr  = fetch_pc_r;
  assign id_valid       = head_valid_s;

  // Show-ahead head, masked to zero whenever the head is not valid.
  always_comb begin
    if (head_valid_s) begin
      id_pc    = pc_mem_r[rd_ptr_r[AW-1:0]];
      id_instr = instr_mem_r[rd_ptr_r[AW-1:0]];
    end else begin
      id_pc    = PC_ZERO;
      id_instr = INSTR_ZERO;
    end
  end

  // Enable flag: keeps requests off while reset is held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active_r <= 1'b0;
    end else begin
      active_r <= 1'b1;
    end
  end

  // Fetch PC: load the aligned target on redirect, step on acceptance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_r <= RESET_PC_ALIGNED;
    end else if (redirect_s) begin
      fetch_pc_r <= target_s;
    end else if (req_fire_s) begin
      fetch_pc_r <= fetch_pc_r + PC_STEP;
    end else begin
      fetch_pc_r <= fetch_pc_r;
    end
  end

  // Response PC: tracks the address of the next kept response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_pc_r <= RESET_PC_ALIGNED;
    end else if (redirect_s) begin
      rsp_pc_r <= target_s;
    end else if (push_s) begin
      rsp_pc_r <= rsp_pc_r + PC_STEP;
    end else begin
      rsp_pc_r <= rsp_pc_r;
    end
  end

  // Outstanding request counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      outstanding_r <= CNT_ZERO;
    end else begin
      outstanding_r <= outstanding_next_s;
    end
  end

  // Drop counter: on redirect every request still in flight becomes stale;
  // a response arriving in the redirect cycle is already discarded, so it is
  // not counted again. No request can be accepted in a redirect cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_r <= CNT_ZERO;
    end else if (redirect_s) begin
      if (imem_rsp_valid) begin
        drop_r <= outstanding_r - CNT_ONE;
      end else begin
        drop_r <= outstanding_r;
      end
    end else if (drop_hit_s) begin
      drop_r <= drop_r - CNT_ONE;
    end else begin
      drop_r <= drop_r;
    end
  end

  // FIFO pointers: a flush simply moves the read pointer onto the write one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= CNT_ZERO;
      rd_ptr_r <= CNT_ZERO;
    end else if (redirect_s) begin
      wr_ptr_r <= wr_ptr_r;
      rd_ptr_r <= wr_ptr_r;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + CNT_ONE;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + CNT_ONE;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
    end
  end

  // FIFO storage write; contents are only observed through valid pointers.
  always_ff @(posedge clk) begin
    if (push_s) begin
      pc_mem_r[wr_ptr_r[AW-1:0]]    <= rsp_pc_r;
      instr_mem_r[wr_ptr_r[AW-1:0]] <= imem_rsp_data;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetched_r;
  logic [31:0] perf_flushed_r;
  logic [31:0] flush_inc_s;

  // Entries lost this cycle: flushed FIFO contents plus a dropped response.
  always_comb begin
    if (redirect_s) begin
      flush_inc_s = 32'(count_s) + {31'd0, imem_rsp_valid};
    end else if (drop_hit_s) begin
      flush_inc_s = 32'd1;
    end else begin
      flush_inc_s = 32'd0;
    end
  end

  // Performance counters, free-running and wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetched_r <= 32'd0;
      perf_flushed_r <= 32'd0;
    end else begin
      perf_fetched_r <= perf_fetched_r + {31'd0, pop_s};
      perf_flushed_r <= perf_flushed_r + flush_inc_s;
    end
  end

  assign perf_fetched = perf_fetched_r;
  assign perf_flushed = perf_flushed_r;
`endif

endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
- Parametrised instruction-fetch stage. Generates the PC and issues in-order requests to instruction memory over a valid/ready channel.
- Buffers returned instructions with their PCs in a DEPTH-entry prefetch FIFO and presents the FIFO head to ID over a valid/ready handshake.
- Branch redirects flush the FIFO and discard in-flight responses.
- Sits between the PC/branch-resolution logic and the IF/ID boundary.

Parameters:
- XLEN, 32, PC and address width
- ILEN, 32, instruction width
- DEPTH, 4, prefetch FIFO entries; power of two, minimum 2
- RESET_PC, 0, fetch address after reset

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low (asserted at 0)
- branch_ctrl  in  2  00 sequential, 01 redirect to pc_imm, 10 redirect to pc_immrs1, 11 treated as 00
- pc_imm  in  XLEN  PC-relative branch/jump target
- pc_immrs1  in  XLEN  register-relative jump target
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  XLEN  fetch address, bits [1:0] always 0
- imem_rsp_valid  in  1  response valid (in order, one per accepted request, no backpressure)
- imem_rsp_data  in  ILEN  fetched instruction
- id_valid  out  1  FIFO head valid
- id_ready  in  1  ID accepts head
- id_pc  out  XLEN  PC of head instruction
- id_instr  out  ILEN  head instruction

Behaviour:
- Reset (rst=0, asynchronous): fetch_pc=RESET_PC, FIFO empty, outstanding=0, drop=0, imem_req_valid=0, id_valid=0, id_pc=0, id_instr=0.
- Redirect: a cycle with branch_ctrl=01 or 10.
- Credit rule: imem_req_valid=1 when no redirect and occupancy+outstanding < DEPTH.
  - Request accepted when imem_req_valid & imem_req_ready.
  - imem_req_addr=fetch_pc. On acceptance: fetch_pc+=4, wrapping mod 2^XLEN. outstanding+1.
- Response (imem_rsp_valid=1): outstanding-1.
  - If drop>0: discard and decrement drop.
  - Otherwise push {pc, instr}; pc comes from an internal response-PC counter that advances by 4 per kept response.
- Latency: a response accepted at edge t appears as the head (id_valid=1) after edge t, when the FIFO was empty. No combinational rsp-to-id path.
- Show-ahead output: id_pc/id_instr reflect the FIFO head. Both are 0 while id_valid=0.
- Head pop on id_valid & id_ready.
- Simultaneous push and pop on a full FIFO: allowed, occupancy unchanged. Credit rule prevents overflow.
- Redirect cycle:
  - id_valid and imem_req_valid forced 0; no pop, no request.
  - FIFO flushed at the edge.
  - fetch_pc and response-PC counter both load the target; target bits [1:0] cleared.
  - drop <= outstanding minus 1 if a response arrives this cycle; that response is itself discarded.
  - First target request may issue the cycle after the redirect.
- Back-to-back redirects: latest target wins; drop accumulates correctly.
- Reset mid-operation: all state cleared immediately. Responses arriving after reset deasserts are undefined (memory is reset together).

Optional Feature:
Macro: IF_PERF_CNT_EN
- Defined:
  - Adds outputs perf_fetched (32-bit): instructions popped to ID.
  - Adds perf_flushed (32-bit): FIFO entries flushed plus responses dropped.
  - Both counters reset to 0, wrap at 2^32, and have no effect on fetch behaviour.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset release, imem_req_ready=1, one-cycle memory, id_ready=1 -> requests at 0x0, 0x4, 0x8…; id_pc 0x0 then 0x4 on consecutive cycles, id_instr matching data.
- id_ready=0 held, DEPTH=4 -> exactly 4 requests accepted, then imem_req_valid=0; releasing id_ready resumes fetch after the first pop.
- Redirect branch_ctrl=01, pc_imm=0x100, with 2 responses in flight and FIFO holding 0x8/0xC -> FIFO emptied, both stale responses dropped, next id_pc=0x100.
- branch_ctrl=10, pc_immrs1=0x203 -> imem_req_addr=0x200; branch_ctrl=11 -> sequential fetch continues.
- fetch_pc=0xFFFFFFFC accepted -> next request address 0x0.
- rst pulsed low mid-burst -> outputs 0 immediately; first post-reset request at RESET_PC. With IF_PERF_CNT_EN, perf_flushed equals flushed plus dropped count in the redirect test.
